// File: rtl/conv_bcd_pkg.sv
// Shared types and constants for the signed result-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_bcd_pkg;

  // Conversion FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 6;
  localparam int MAX_WIDTH     = 6;
  localparam int BCD_W         = 4;
  localparam int DIGITS        = 2;

  // Iteration counter only needs to reach MAX_WIDTH-1
  localparam int CNT_W         = $clog2(MAX_WIDTH);

endpackage

// File: rtl/bcd_add3_dig.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3_dig
  import conv_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] dig_i,
  output logic [BCD_W-1:0] dig_o
);

  // Pre-shift correction so the following left shift carries into the next digit
  always_comb begin
    dig_o = dig_i;
    if (dig_i >= 4'd5) begin
      dig_o = dig_i + 4'd3;
    end
  end

endmodule

// File: rtl/conv_bcd_signed.sv
// Signed ALU result to sign + two BCD digits via iterative shift-add-3.
// Latency: done pulses WIDTH+1 cycles after start; next start accepted WIDTH+2 cycles after.
// Backpressure: start ignored while busy or in DONE; CONV_BCD_SIGNED_EN enables signed input.
module conv_bcd_signed
  import conv_bcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH  // 4..6; two BCD digits cover the range
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  // Working register: BCD digits sit above the binary magnitude bits
  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int WR_W    = WIDTH + BCD_TOT;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WR_W-1:0]      work_q;
  logic [WR_W-1:0]      work_d;
  logic                 sign_r_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 sign_q;
  logic [BCD_W-1:0]     tens_q;
  logic [BCD_W-1:0]     ones_q;

  logic                 sign_d;
  logic [WIDTH-1:0]     mag_d;
  logic [BCD_TOT-1:0]   bcd_fix;

`ifdef CONV_BCD_SIGNED_EN
  // Two's complement magnitude; the most negative value maps onto its unsigned bit pattern
  assign sign_d = result[WIDTH-1];
  assign mag_d  = sign_d ? (~result + {{(WIDTH-1){1'b0}}, 1'b1}) : result;
`else
  // Unsigned operand: no negation, sign never set
  assign sign_d = 1'b0;
  assign mag_d  = result;
`endif

  // One correction unit per BCD digit of the working register
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3_dig u_add3 (
      .dig_i (work_q[WIDTH + g*BCD_W +: BCD_W]),
      .dig_o (bcd_fix[g*BCD_W +: BCD_W])
    );
  end

  // Corrected digits followed by a one-bit left shift of the whole register
  assign work_d = {bcd_fix, work_q[WIDTH-1:0]} << 1;

  // Conversion FSM with registered handshake and digit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      tens_q   <= '0;
      ones_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sign_r_q <= sign_d;
            work_q   <= {{BCD_TOT{1'b0}}, mag_d};
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // busy stays high through the cycle in which done is visible
          tens_q  <= work_q[WIDTH + BCD_W +: BCD_W];
          ones_q  <= work_q[WIDTH +: BCD_W];
          sign_q  <= sign_r_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sign = sign_q;
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: doc/conv_bcd_signed.md
# conv_bcd_signed

Sequential result-to-display converter placed directly downstream of the ALU's two's-complement stage. It accepts a 6-bit signed ALU result on a start strobe, extracts sign and magnitude, and runs an iterative shift-add-3 (double-dabble) conversion. It presents a sign flag plus two BCD digits (tens, ones) that drive the seven-segment display logic, with a busy/done handshake.

## Interface
Parameters:
- WIDTH, 6, result width in bits; supported range 4–6 (two BCD digits suffice).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request conversion of `result`; sampled only in IDLE.
- result  input  WIDTH  ALU result, two's complement (see Configuration).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- sign  output  1  1 = negative result.
- tens  output  4  BCD tens digit.
- ones  output  4  BCD ones digit.

## Operation
- FSM states:
  - IDLE: busy=0. If start=1, go to SHIFT.
  - SHIFT: runs exactly WIDTH iterations, then goes to DONE.
  - DONE: outputs load, done=1, then return to IDLE.
- Capture, on the edge leaving IDLE:
  - sign_r = result[WIDTH-1].
  - mag = sign_r ? (~result + 1) truncated to WIDTH bits : result.
  - mag is interpreted as unsigned, so -32 (100000) gives mag 32, which is correct.
  - Shift register = {8'b0, mag}; iteration counter = 0.
- Each SHIFT cycle:
  - Add 3 to each BCD nibble that is ≥5.
  - Then shift the whole register left by 1.
  - Increment the counter; leave SHIFT after count WIDTH-1.
- DONE cycle: tens/ones/sign registers load from the working register. done is high for exactly this cycle.
- start while busy or in DONE is ignored. There is no queueing, and `result` is not resampled.
- Outputs hold their last converted values between conversions.
- Reset (any time, including mid-conversion):
  - FSM goes to IDLE, counter and working register clear.
  - busy=0, done=0, sign=0, tens=0, ones=0.
  - The aborted conversion produces no done.
- Back-to-back use: start may be held high. A new conversion begins on the first edge in IDLE after DONE.

## Timing
- Edge 0: start=1 sampled in IDLE; operand captured; busy rises after edge 0.
- Edges 1..WIDTH: shift iterations (6 for the default).
- Edge WIDTH+1 (7): outputs update and done rises. busy stays high through the DONE cycle.
- Edge WIDTH+2 (8): done=0, busy=0, FSM in IDLE.
- Start-to-done latency is WIDTH+1 cycles. Minimum start-to-start spacing is WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: CONV_BCD_SIGNED_EN.
- Defined:
  - `result` is two's complement and sign/magnitude extraction is active.
  - Range is -2^(WIDTH-1)..2^(WIDTH-1)-1.
- Undefined:
  - `result` is unsigned 0..2^WIDTH-1 (tens up to 6 for WIDTH=6).
  - The negation logic is absent and sign is tied to 0.

## Structure
- Shared package conv_bcd_pkg:
  - FSM state enum (IDLE, SHIFT, DONE).
  - Default width constant.
  - BCD nibble width (4) and digit count (2).
  - Counter width: $clog2 of the maximum supported WIDTH.
- Sub-module bcd_add3_dig: combinational 4-bit "if ≥5 add 3" correction, instantiated once per digit.

## Test plan
- Reset: assert rst_n=0 mid-SHIFT with result=6'b011111 → all outputs 0, busy=0, and no done pulse after release.
- Positive: result=6'd27, start pulse → done exactly 7 cycles after start; sign=0, tens=2, ones=7.
- Negative extreme (SIGNED_EN): result=6'b100000 → sign=1, tens=3, ones=2. result=6'b111111 → sign=1, tens=0, ones=1.
- Zero and max: result=0 → sign=0, tens=0, ones=0. result=6'd31 → tens=3, ones=1.
- Handshake: start pulsed again at cycles 2 and 7 of a conversion → ignored; one done only; outputs reflect the first operand. With start held high, a second done arrives 8 cycles after the first.
- Unsigned build (macro undefined): result=6'b111111 → sign=0, tens=6, ones=3.
